wave_sample_fetch: RTL and testbench



---
 rtl/bit_blender_audio_pkg.sv | 17 +
 rtl/sample_scaler.sv | 39 +++
 rtl/wave_sample_fetch.sv | 155 +++++++++++++++
 tb/tb_wave_sample_fetch.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bit_blender_audio_pkg.sv
// Shared types and constants for the per-voice audio sample path.
package bit_blender_audio_pkg;

  typedef logic signed [15:0] sample_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    SCALE,
    HOLD
  } fetch_state_t;

  localparam int unsigned SAMPLE_SHIFT = 8;
  localparam logic [15:0] INDEX_NONE   = 16'hFFFF;

endpackage

// File: rtl/sample_scaler.sv
// Registered signed x unsigned multiply followed by an arithmetic right shift.
module sample_scaler #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned GAIN_W = 8,
  parameter int unsigned SHIFT  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     clr,
  input  logic signed [DATA_W-1:0] data,
  input  logic        [GAIN_W-1:0] gain,
  output logic signed [DATA_W-1:0] result
);

  localparam int unsigned ProdW = DATA_W + GAIN_W + 1;

  logic signed [ProdW-1:0] data_ext;
  logic signed [ProdW-1:0] gain_ext;
  logic signed [ProdW-1:0] product;

  // Gain is zero-extended so it always multiplies as a non-negative value.
  always_comb begin
    data_ext = ProdW'(data);
    gain_ext = $signed(ProdW'(gain));
    product  = data_ext * gain_ext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
    end else if (clr) begin
      result <= '0;
    end else if (en) begin
      result <= DATA_W'(product >>> SHIFT);
    end
  end

endmodule

// File: rtl/wave_sample_fetch.sv
// Per-voice wavetable fetch: index -> BRAM read -> volume scale -> valid/ready stream.
// Optional fade-in ramp enabled by defining SAMPLE_FETCH_FADE_EN.
module wave_sample_fetch
  import bit_blender_audio_pkg::*;
#(
  parameter int unsigned RAM_LATENCY = 2,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned GAIN_W      = 8
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              is_on_in,
  input  logic [15:0]       sample_index_in,
  input  logic [ADDR_W-1:0] wave_base_in,
  input  logic [GAIN_W-1:0] volume_in,
  output logic [ADDR_W-1:0] addr_out,
  output logic              rd_en_out,
  input  logic [15:0]       rd_data_in,
  output logic [15:0]       sample_out,
  output logic              sample_valid_out,
  input  logic              sample_ready_in
);

  fetch_state_t state;
  logic         pending;
  logic [15:0]  pend_index;
  logic [15:0]  last_index;
  logic         is_on_q;
  logic [2:0]   wait_cnt;
  sample_t      rd_data_q;
  sample_t      scaled;
  logic [GAIN_W-1:0] gain;

  logic        trigger;
  logic        issue;
  logic        scale_en;
  logic        scale_clr;
  logic [15:0] issue_index;

  // A fresh trigger may be issued in the same cycle it is seen, so the
  // pending slot only holds indices that arrive while the datapath is busy.
  always_comb begin
    trigger     = is_on_in && (!is_on_q || (sample_index_in != last_index));
    issue       = (pending || trigger) &&
                  ((state == IDLE) || ((state == HOLD) && sample_ready_in));
    issue_index = trigger ? sample_index_in : pend_index;
    scale_en    = (state == SCALE);
    scale_clr   = !is_on_in;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state            <= IDLE;
      pending          <= 1'b0;
      pend_index       <= '0;
      last_index       <= INDEX_NONE;
      is_on_q          <= 1'b0;
      wait_cnt         <= '0;
      rd_data_q        <= '0;
      addr_out         <= '0;
      rd_en_out        <= 1'b0;
      sample_valid_out <= 1'b0;
    end else begin
      is_on_q <= is_on_in;
      if (!is_on_in) begin
        // Voice off: drop any in-flight read and forget the last index.
        state            <= IDLE;
        pending          <= 1'b0;
        last_index       <= INDEX_NONE;
        rd_en_out        <= 1'b0;
        sample_valid_out <= 1'b0;
      end else begin
        rd_en_out <= 1'b0;
        if (trigger) begin
          last_index <= sample_index_in;
          pend_index <= sample_index_in;
        end
        if (issue) begin
          pending   <= 1'b0;
          addr_out  <= wave_base_in + ADDR_W'(issue_index);
          rd_en_out <= 1'b1;
        end else if (trigger) begin
          pending <= 1'b1;
        end

        unique case (state)
          IDLE: begin
            if (issue) state <= ISSUE;
          end
          ISSUE: begin
            wait_cnt <= '0;
            state    <= WAIT;
          end
          WAIT: begin
            if (wait_cnt == 3'(RAM_LATENCY - 1)) begin
              rd_data_q <= rd_data_in;
              state     <= SCALE;
            end else begin
              wait_cnt <= wait_cnt + 3'd1;
            end
          end
          SCALE: begin
            sample_valid_out <= 1'b1;
            state            <= HOLD;
          end
          HOLD: begin
            if (sample_ready_in) begin
              sample_valid_out <= 1'b0;
              state            <= issue ? ISSUE : IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef SAMPLE_FETCH_FADE_EN
  logic [7:0] ramp;
  logic       handshake;

  assign handshake = sample_valid_out && sample_ready_in;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ramp <= '0;
    end else if (is_on_in && !is_on_q) begin
      ramp <= '0;
    end else if (handshake && (ramp != 8'hFF)) begin
      ramp <= ramp + 8'd1;
    end
  end

  assign gain = (GAIN_W'(ramp) < volume_in) ? GAIN_W'(ramp) : volume_in;
`else
  assign gain = volume_in;
`endif

  sample_scaler #(
    .DATA_W(16),
    .GAIN_W(GAIN_W),
    .SHIFT (SAMPLE_SHIFT)
  ) u_scaler (
    .clk   (clk_in),
    .rst_n (rst_n_in),
    .en    (scale_en),
    .clr   (scale_clr),
    .data  (rd_data_q),
    .gain  (gain),
    .result(scaled)
  );

  assign sample_out = scaled;

endmodule

// File: tb/tb_wave_sample_fetch.sv
// Self-checking bench for wave_sample_fetch: vector table, corner sequences, random traffic.
module tb_wave_sample_fetch;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        is_on = 1'b0;
  logic        ready = 1'b0;
  logic [15:0] idx = '0;
  logic [15:0] base = '0;
  logic [7:0]  vol = '0;
  logic [15:0] addr;
  logic [15:0] rd_data;
  logic [15:0] sample;
  logic        rd_en;
  logic        valid;

  int          checks = 0;
  int          errors = 0;
  int          nreads = 0;
  logic [15:0] last_addr = '0;
  int          ramp_m = 0;

  logic [15:0] mem [65536];
  logic [15:0] pipe [L];

  typedef struct {
    logic [15:0] base;
    logic [15:0] idx;
    logic [7:0]  vol;
    logic [15:0] data;
    logic [15:0] exp_addr;
    logic [15:0] exp_sample;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  wave_sample_fetch #(
    .RAM_LATENCY(L),
    .ADDR_W     (16),
    .GAIN_W     (8)
  ) dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .is_on_in        (is_on),
    .sample_index_in (idx),
    .wave_base_in    (base),
    .volume_in       (vol),
    .addr_out        (addr),
    .rd_en_out       (rd_en),
    .rd_data_in      (rd_data),
    .sample_out      (sample),
    .sample_valid_out(valid),
    .sample_ready_in (ready)
  );

  // BRAM model: data appears L cycles after the strobe, junk otherwise.
  assign rd_data = pipe[L-1];
  always @(posedge clk) begin
    pipe[0] <= rd_en ? mem[addr] : 16'($urandom);
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    if (rd_en) begin
      nreads    <= nreads + 1;
      last_addr <= addr;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // floor(data * gain / 256) on plain integers.
  function automatic logic [15:0] scale_ref(input logic [15:0] d, input int g);
    int p;
    int q;
    p = int'($signed(d)) * g;
    if (p >= 0) q = p / 256;
    else q = -((-p + 255) / 256);
    return q[15:0];
  endfunction

  function automatic int eff_gain(input int v);
`ifdef SAMPLE_FETCH_FADE_EN
    return (ramp_m < v) ? ramp_m : v;
`else
    return v;
`endif
  endfunction

  task automatic wait_valid(output int n);
    n = 0;
    while (valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic handshake;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    if (ramp_m < 255) ramp_m++;
  endtask

  // Call right after the inputs that cause the trigger have been applied.
  task automatic fetch_check(input string name, input logic [15:0] exp_addr,
                             input logic [15:0] exp_sample, input int hold);
    int n;
    int r0;
    r0 = nreads;
    wait_valid(n);
    chkn({name, " latency"}, n, L + 3);
    chk16({name, " sample"}, sample, exp_sample);
    chk16({name, " addr"}, last_addr, exp_addr);
    chkn({name, " reads"}, nreads - r0, 1);
    for (int i = 0; i < hold; i++) begin
      tick();
      chkn({name, " held valid"}, int'(valid), 1);
      chk16({name, " held sample"}, sample, exp_sample);
    end
    handshake();
    chkn({name, " valid drop"}, int'(valid), 0);
  endtask

  logic [15:0] ni;
  logic [15:0] d;
  logic [15:0] e5;
  logic [15:0] e7;
  int          n;
  int          r0;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);

    vecs[0] = '{16'h0100, 16'h0000, 8'd128, 16'h4000, 16'h0100, 16'h2000};
    vecs[1] = '{16'hFFFE, 16'h0003, 8'd128, 16'h1234, 16'h0001, 16'h091A};
    vecs[2] = '{16'h0000, 16'h0005, 8'd255, 16'h8000, 16'h0005, 16'h8080};
    vecs[3] = '{16'h0000, 16'h0006, 8'd0,   16'h7FFF, 16'h0006, 16'h0000};
    vecs[4] = '{16'h1000, 16'h0007, 8'd255, 16'h7FFF, 16'h1007, 16'h7F7F};
    vecs[5] = '{16'h2000, 16'h0008, 8'd1,   16'hFFFF, 16'h2008, 16'hFFFF};
    vecs[6] = '{16'h2000, 16'h0009, 8'd64,  16'h8001, 16'h2009, 16'hE000};

    #12;
    chk16("reset addr", addr, 16'h0000);
    chkn("reset rd_en", int'(rd_en), 0);
    chkn("reset valid", int'(valid), 0);
    chk16("reset sample", sample, 16'h0000);
    tick();
    rst_n = 1'b1;
    is_on = 1'b1;

    for (int i = 0; i < 7; i++) begin
      base = vecs[i].base;
      vol  = vecs[i].vol;
      mem[vecs[i].exp_addr] = vecs[i].data;
      idx  = vecs[i].idx;
`ifdef SAMPLE_FETCH_FADE_EN
      fetch_check($sformatf("vec%0d", i), vecs[i].exp_addr,
                  scale_ref(vecs[i].data, eff_gain(int'(vecs[i].vol))), i % 3);
`else
      fetch_check($sformatf("vec%0d", i), vecs[i].exp_addr, vecs[i].exp_sample, i % 3);
`endif
    end

    // Consumer stalls while the index moves 5 -> 6 -> 7: 6 must never be read.
    base = 16'h0300;
    vol  = 8'd128;
    mem[16'h0305] = 16'h1111;
    mem[16'h0306] = 16'h2222;
    mem[16'h0307] = 16'h3333;
    idx = 16'h0005;
    wait_valid(n);
    chkn("stall latency", n, L + 3);
    e5 = scale_ref(16'h1111, eff_gain(128));
    chk16("stall first sample", sample, e5);
    r0 = nreads;
    idx = 16'h0006;
    repeat (3) tick();
    idx = 16'h0007;
    repeat (3) tick();
    chkn("stall valid held", int'(valid), 1);
    chk16("stall sample held", sample, e5);
    chkn("stall no read", nreads - r0, 0);
    handshake();
    chkn("stall valid drop", int'(valid), 0);
    e7 = scale_ref(16'h3333, eff_gain(128));
    wait_valid(n);
    chk16("stall latest sample", sample, e7);
    chk16("stall latest addr", last_addr, 16'h0307);
    chkn("stall one read", nreads - r0, 1);
    handshake();
    repeat (6) tick();
    chkn("stall no extra read", nreads - r0, 1);

    // Voice switched off while the read is in flight.
    base = 16'h0500;
    vol  = 8'd200;
    mem[16'h0500] = 16'h0ABC;
    idx = 16'h0000;
    fetch_check("on idx0", 16'h0500, scale_ref(16'h0ABC, eff_gain(200)), 0);
    idx = 16'h0011;
    repeat (3) tick();
    is_on = 1'b0;
    r0 = nreads;
    for (int i = 0; i < 8; i++) begin
      tick();
      chkn("off valid", int'(valid), 0);
      chk16("off sample", sample, 16'h0000);
    end
    chkn("off no read", nreads - r0, 0);
    mem[16'h0500] = 16'h1357;
    idx = 16'h0000;
    is_on = 1'b1;
    ramp_m = 0;
    fetch_check("reenable idx0", 16'h0500, scale_ref(16'h1357, eff_gain(200)), 1);

    // Asynchronous reset in the middle of a fetch.
    base = 16'h0600;
    vol  = 8'd100;
    mem[16'h0622] = 16'h7000;
    idx = 16'h0022;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk16("async addr", addr, 16'h0000);
    chkn("async rd_en", int'(rd_en), 0);
    chkn("async valid", int'(valid), 0);
    chk16("async sample", sample, 16'h0000);
    repeat (2) tick();
    mem[16'h0623] = 16'h0F00;
    idx = 16'h0023;
    rst_n = 1'b1;
    ramp_m = 0;
    fetch_check("post reset", 16'h0623, scale_ref(16'h0F00, eff_gain(100)), 0);

`ifdef SAMPLE_FETCH_FADE_EN
    is_on = 1'b0;
    repeat (2) tick();
    base = 16'h0700;
    vol  = 8'd255;
    for (int k = 0; k < 260; k++) mem[16'h0700 + 16'(k)] = 16'h7FFF;
    idx = 16'h0000;
    is_on = 1'b1;
    ramp_m = 0;
    for (int k = 0; k < 260; k++) begin
      idx = 16'(k);
      fetch_check($sformatf("fade%0d", k), 16'h0700 + 16'(k),
                  scale_ref(16'h7FFF, eff_gain(255)), 0);
    end
`endif

    // Random traffic against the arithmetic reference.
    for (int k = 0; k < 40; k++) begin
      ni = 16'($urandom);
      if (ni == idx) ni = ni ^ 16'h0001;
      base = 16'($urandom);
      vol  = 8'($urandom);
      d    = 16'($urandom);
      mem[16'(base + ni)] = d;
      idx = ni;
      fetch_check($sformatf("rand%0d", k), 16'(base + ni),
                  scale_ref(d, eff_gain(int'(vol))), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
